// File: rtl/beer_pkg.sv
// Shared constants and helpers for the beer slider: lane rows, launch columns
// and default geometry/timing parameters.
package beer_pkg;

    localparam logic [10:0] LANE_0 = 11'd125;
    localparam logic [10:0] LANE_1 = 11'd175;
    localparam logic [10:0] LANE_2 = 11'd225;
    localparam logic [10:0] LANE_3 = 11'd275;
    localparam logic [10:0] LANE_4 = 11'd325;
    localparam logic [10:0] LANE_5 = 11'd375;

    localparam logic [10:0] X_P1 = 11'd80;
    localparam logic [10:0] X_P2 = 11'd560;

    localparam int          N_MUG_DEF    = 4;
    localparam logic [10:0] STEP_DEF     = 11'd8;
    localparam int          COOLDOWN_DEF = 8;

    function automatic logic lane_valid(input logic [10:0] y);
        case (y)
            LANE_0, LANE_1, LANE_2, LANE_3, LANE_4, LANE_5: lane_valid = 1'b1;
            default:                                        lane_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/beer_slider_mug_slot.sv
// One mug slot: holds position and lane, slides it one step per clock and
// flags arrival at the far end so the top can emit catch/miss pulses.
module mug_slot
    import beer_pkg::*;
#(
    parameter logic [10:0] STEP = STEP_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        dir_i,
    input  logic        load_i,
    input  logic [10:0] load_y_i,
    output logic        valid_o,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic        arrive_o
);

    logic        valid_q, valid_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [11:0] fwd_s;
    logic        hit_s;

    // Arrival test; the forward sum is widened and the reverse compare avoids subtraction
    always_comb begin
        fwd_s = {1'b0, x_q} + {1'b0, STEP};
        hit_s = dir_i ? (x_q <= (X_P1 + STEP)) : (fwd_s >= {1'b0, X_P2});
    end

    // Next slot state: run-clear, launch, arrival clear, or step
    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        if (!run_i) begin
            valid_d = 1'b0;
            x_d     = 11'd0;
            y_d     = 11'd0;
        end else if (load_i) begin
            valid_d = 1'b1;
            x_d     = dir_i ? X_P2 : X_P1;
            y_d     = load_y_i;
        end else if (valid_q && hit_s) begin
            valid_d = 1'b0;
            x_d     = 11'd0;
            y_d     = 11'd0;
        end else if (valid_q) begin
            x_d = dir_i ? (x_q - STEP) : (x_q + STEP);
        end else begin
            x_d = x_q;
        end
    end

    // Slot state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            x_q     <= 11'd0;
            y_q     <= 11'd0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign valid_o  = valid_q;
    assign x_o      = x_q;
    assign y_o      = y_q;
    assign arrive_o = valid_q & hit_s;

endmodule

// File: rtl/beer_slider.sv
// Beer slider playfield: accepts fires, allocates mug slots per player,
// and pulses catch/miss when mugs reach the opposite bartender.
module beer_slider
    import beer_pkg::*;
#(
    parameter int          N_MUG    = N_MUG_DEF,
    parameter logic [10:0] STEP     = STEP_DEF,
    parameter int          COOLDOWN = COOLDOWN_DEF
) (
    input  logic                   CLK_2_21,
    input  logic                   RESET,
    input  logic                   run,
    input  logic [10:0]            P1_y,
    input  logic [10:0]            P2_y,
    input  logic                   fire_p1,
    input  logic                   fire_p2,
    output logic                   p1_life_dec,
    output logic                   p2_life_dec,
    output logic                   p1_catch,
    output logic                   p2_catch,
    output logic [2*N_MUG-1:0]     mug_valid,
    output logic [2*N_MUG*11-1:0]  mug_x,
    output logic [2*N_MUG*11-1:0]  mug_y
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] CD_LOAD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

    logic [2*N_MUG-1:0] arrive_s;
    logic [2*N_MUG-1:0] load_s;
    logic [N_MUG-1:0]   p1_valid_s, p2_valid_s;
    logic               acc1_s, acc2_s;
    logic [CW-1:0]      cd1_q, cd1_d, cd2_q, cd2_d;
    logic               p1_life_q, p1_life_d, p2_life_q, p2_life_d;
    logic               p1_catch_q, p1_catch_d, p2_catch_q, p2_catch_d;

    function automatic logic [N_MUG-1:0] first_free(input logic [N_MUG-1:0] v);
        first_free = '0;
        for (int i = N_MUG - 1; i >= 0; i--) begin
            if (!v[i]) begin
                first_free    = '0;
                first_free[i] = 1'b1;
            end else begin
                first_free = first_free;
            end
        end
    endfunction

    assign p1_valid_s = mug_valid[N_MUG-1:0];
    assign p2_valid_s = mug_valid[2*N_MUG-1:N_MUG];

    // Fire acceptance and slot allocation from pre-edge valid flags
    always_comb begin
        acc1_s = run & fire_p1 & lane_valid(P1_y) & (cd1_q == '0) & ~(&p1_valid_s);
        acc2_s = run & fire_p2 & lane_valid(P2_y) & (cd2_q == '0) & ~(&p2_valid_s);
        load_s[N_MUG-1:0]       = acc1_s ? first_free(p1_valid_s) : '0;
        load_s[2*N_MUG-1:N_MUG] = acc2_s ? first_free(p2_valid_s) : '0;
    end

    // Cooldown counters: load on accept, count down to zero
    always_comb begin
        cd1_d = cd1_q;
        cd2_d = cd2_q;
        if (!run) begin
            cd1_d = '0;
            cd2_d = '0;
        end else begin
            cd1_d = acc1_s ? CD_LOAD : ((cd1_q != '0) ? cd1_q - 1'b1 : cd1_q);
            cd2_d = acc2_s ? CD_LOAD : ((cd2_q != '0) ? cd2_q - 1'b1 : cd2_q);
        end
    end

    // Merge all arrivals at each player into at most one pulse per kind
    always_comb begin
        p1_life_d  = 1'b0;
        p2_life_d  = 1'b0;
        p1_catch_d = 1'b0;
        p2_catch_d = 1'b0;
        for (int i = 0; i < 2 * N_MUG; i++) begin
            if (run && arrive_s[i] && (i < N_MUG)) begin
                if (mug_y[i*11 +: 11] == P2_y) p2_catch_d = 1'b1;
                else                           p2_life_d  = 1'b1;
            end else if (run && arrive_s[i]) begin
                if (mug_y[i*11 +: 11] == P1_y) p1_catch_d = 1'b1;
                else                           p1_life_d  = 1'b1;
            end else begin
                p1_life_d = p1_life_d;
            end
        end
    end

    // Cooldown and pulse registers
    always_ff @(posedge CLK_2_21 or posedge RESET) begin
        if (RESET) begin
            cd1_q      <= '0;
            cd2_q      <= '0;
            p1_life_q  <= 1'b0;
            p2_life_q  <= 1'b0;
            p1_catch_q <= 1'b0;
            p2_catch_q <= 1'b0;
        end else begin
            cd1_q      <= cd1_d;
            cd2_q      <= cd2_d;
            p1_life_q  <= p1_life_d;
            p2_life_q  <= p2_life_d;
            p1_catch_q <= p1_catch_d;
            p2_catch_q <= p2_catch_d;
        end
    end

    assign p1_life_dec = p1_life_q;
    assign p2_life_dec = p2_life_q;
    assign p1_catch    = p1_catch_q;
    assign p2_catch    = p2_catch_q;

    // P1 slots in the low half travel right, P2 slots in the high half travel left
    for (genvar g = 0; g < 2 * N_MUG; g++) begin : g_slot
        mug_slot #(.STEP(STEP)) u_slot (
            .clk_i    (CLK_2_21),
            .rst_i    (RESET),
            .run_i    (run),
            .dir_i    ((g >= N_MUG) ? 1'b1 : 1'b0),
            .load_i   (load_s[g]),
            .load_y_i ((g >= N_MUG) ? P2_y : P1_y),
            .valid_o  (mug_valid[g]),
            .x_o      (mug_x[g*11 +: 11]),
            .y_o      (mug_y[g*11 +: 11]),
            .arrive_o (arrive_s[g])
        );
    end

endmodule
